ili934x_win_streamer: RTL

Window-write sequencer for the ILI934x TFT path. On a start request it latches a rectangle, emits the CASET/PASET/RAMWR command sequence with its parameter bytes, then streams RGB565 pixels from a pixel handshake as high/low byte pairs. Its output is a `wr_item_t` stream that drives source B of the two-source arbiter ahead of the write FIFO. Init traffic on source A keeps priority and simply stalls this block through `o_ready`.

---
 rtl/ili934x_win_streamer.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/ili934x_win_streamer.sv
// ILI934x window-write sequencer: CASET/PASET/RAMWR header followed by RGB565 pixels
// sent as high/low byte pairs. o_item is {is_cmd, byte}, the wr_item_t layout of the arbiter.
module ili934x_win_streamer (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [15:0] x0,
   input  logic [15:0] x1,
   input  logic [15:0] y0,
   input  logic [15:0] y1,
   output logic        busy,
   output logic        done,
   output logic        err,
   input  logic        pix_valid,
   input  logic [15:0] pix_data,
   output logic        pix_ready,
   output logic        o_valid,
   output logic [8:0]  o_item,
   input  logic        o_ready
);

   typedef enum logic [4:0] {
      S_IDLE, S_CMD_CA, S_PAR_CA0, S_PAR_CA1, S_PAR_CA2, S_PAR_CA3,
      S_CMD_PA, S_PAR_PA0, S_PAR_PA1, S_PAR_PA2, S_PAR_PA3, S_CMD_WR,
      S_PIX_FETCH, S_PIX_HI, S_PIX_LO, S_DONE
   } state_t;

   state_t      state_r;
   state_t      hdr_next_s;
   logic [8:0]  hdr_item_s;
   logic [15:0] x0_r, x1_r, y0_r, y1_r;
   logic [15:0] col_r, row_r, hold_r;
   logic [15:0] x_span_s, y_span_s;
   logic        col_last_s, row_last_s, accept_s;

   // Spans from latched corners; non-negative because start validated x1>=x0, y1>=y0
   always_comb begin
      x_span_s   = x1_r - x0_r;
      y_span_s   = y1_r - y0_r;
      col_last_s = (col_r == x_span_s);
      row_last_s = (row_r == y_span_s);
      accept_s   = o_valid && o_ready;
   end

   // Header walk: successor state and the item it presents
   always_comb begin
      hdr_next_s = state_r;
      hdr_item_s = o_item;
      case (state_r)
         S_CMD_CA:  begin hdr_next_s = S_PAR_CA0;   hdr_item_s = {1'b0, x0_r[15:8]}; end
         S_PAR_CA0: begin hdr_next_s = S_PAR_CA1;   hdr_item_s = {1'b0, x0_r[7:0]};  end
         S_PAR_CA1: begin hdr_next_s = S_PAR_CA2;   hdr_item_s = {1'b0, x1_r[15:8]}; end
         S_PAR_CA2: begin hdr_next_s = S_PAR_CA3;   hdr_item_s = {1'b0, x1_r[7:0]};  end
         S_PAR_CA3: begin hdr_next_s = S_CMD_PA;    hdr_item_s = {1'b1, 8'h2B};      end
         S_CMD_PA:  begin hdr_next_s = S_PAR_PA0;   hdr_item_s = {1'b0, y0_r[15:8]}; end
         S_PAR_PA0: begin hdr_next_s = S_PAR_PA1;   hdr_item_s = {1'b0, y0_r[7:0]};  end
         S_PAR_PA1: begin hdr_next_s = S_PAR_PA2;   hdr_item_s = {1'b0, y1_r[15:8]}; end
         S_PAR_PA2: begin hdr_next_s = S_PAR_PA3;   hdr_item_s = {1'b0, y1_r[7:0]};  end
         S_PAR_PA3: begin hdr_next_s = S_CMD_WR;    hdr_item_s = {1'b1, 8'h2C};      end
         S_CMD_WR:  begin hdr_next_s = S_PIX_FETCH; hdr_item_s = 9'h000;             end
         default:   begin hdr_next_s = state_r;     hdr_item_s = o_item;             end
      endcase
   end

   // Sequencer FSM; all outputs registered so they only move with state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r   <= S_IDLE;
         x0_r      <= 16'h0000;
         x1_r      <= 16'h0000;
         y0_r      <= 16'h0000;
         y1_r      <= 16'h0000;
         col_r     <= 16'h0000;
         row_r     <= 16'h0000;
         hold_r    <= 16'h0000;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         pix_ready <= 1'b0;
         o_valid   <= 1'b0;
         o_item    <= 9'h000;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         case (state_r)
            S_IDLE: begin
               if (start) begin
                  if ((x1 >= x0) && (y1 >= y0)) begin
                     x0_r    <= x0;
                     x1_r    <= x1;
                     y0_r    <= y0;
                     y1_r    <= y1;
                     col_r   <= 16'h0000;
                     row_r   <= 16'h0000;
                     busy    <= 1'b1;
                     o_valid <= 1'b1;
                     o_item  <= {1'b1, 8'h2A};
                     state_r <= S_CMD_CA;
                  end else begin
                     err <= 1'b1;
                  end
               end
            end
            S_CMD_CA, S_PAR_CA0, S_PAR_CA1, S_PAR_CA2, S_PAR_CA3,
            S_CMD_PA, S_PAR_PA0, S_PAR_PA1, S_PAR_PA2, S_PAR_PA3, S_CMD_WR: begin
               if (accept_s) begin
                  state_r <= hdr_next_s;
                  o_item  <= hdr_item_s;
                  if (state_r == S_CMD_WR) begin
                     o_valid   <= 1'b0;
                     pix_ready <= 1'b1;
                  end
               end
            end
            S_PIX_FETCH: begin
               if (pix_valid) begin
                  hold_r    <= pix_data;
                  pix_ready <= 1'b0;
                  o_valid   <= 1'b1;
                  o_item    <= {1'b0, pix_data[15:8]};
                  state_r   <= S_PIX_HI;
               end
            end
            S_PIX_HI: begin
               if (accept_s) begin
                  o_item  <= {1'b0, hold_r[7:0]};
                  state_r <= S_PIX_LO;
               end
            end
            S_PIX_LO: begin
               if (accept_s) begin
                  o_valid <= 1'b0;
                  o_item  <= 9'h000;
                  if (col_last_s && row_last_s) begin
                     done    <= 1'b1;
                     state_r <= S_DONE;
                  end else if (col_last_s) begin
                     col_r     <= 16'h0000;
                     row_r     <= row_r + 16'h0001;
                     pix_ready <= 1'b1;
                     state_r   <= S_PIX_FETCH;
                  end else begin
                     col_r     <= col_r + 16'h0001;
                     pix_ready <= 1'b1;
                     state_r   <= S_PIX_FETCH;
                  end
               end
            end
            S_DONE: begin
               busy    <= 1'b0;
               state_r <= S_IDLE;
            end
            default: begin
               busy      <= 1'b0;
               o_valid   <= 1'b0;
               pix_ready <= 1'b0;
               o_item    <= 9'h000;
               state_r   <= S_IDLE;
            end
         endcase
      end
   end

endmodule
